// File: rtl/uart_pkg.sv
// Shared definitions for the mylib/uart transmitter and receiver.
// Line format is fixed 8N1; clock and baud defaults match the reference board.
package uart_pkg;

  localparam int unsigned FRE_DEF  = 50_000_000;
  localparam int unsigned BAUD_DEF = 115_200;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StStart = 6'b000010,
    StData  = 6'b000100,
    StStop  = 6'b001000,
    StDone  = 6'b010000,
    StErr   = 6'b100000
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned fre, input int unsigned baud);
    return fre / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, byte/valid/error/busy out.
// The receiver takes the master view; the byte consumer (and the line driver) the slave view.
interface uart_rx_if;
  import uart_pkg::*;

  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic              rx_busy;

  modport master (
    input  rxd,
    output rx_data,
    output rx_valid,
    output rx_err,
    output rx_busy
  );

  modport slave (
    output rxd,
    input  rx_data,
    input  rx_valid,
    input  rx_err,
    input  rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an idle-high asynchronous pin, plus a falling-edge pulse.
// Flops reset to 1 so a reset never manufactures an edge on an idle line.
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic uclk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall_pulse
);

  // STAGES synchroniser flops followed by one history flop for edge detection
  logic [STAGES:0] sync_q;

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-1:0], din};
    end
  end

  assign dout       = sync_q[STAGES-1];
  assign fall_pulse = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: verifies the start bit at mid-period, samples each bit mid-period and
// reports the byte with a one-cycle valid pulse, or a one-cycle framing-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FRE  = FRE_DEF,
  parameter int unsigned BAUD = BAUD_DEF
) (
  input logic       uclk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int unsigned BPS_CNT  = clks_per_bit(FRE, BAUD);
  localparam int unsigned HALF_CNT = BPS_CNT / 2;

  localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [15:0]       clk_cnt_q, clk_cnt_d;
  logic [3:0]        data_cnt_q, data_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic rxd_s;
  logic fall_pulse;

  uart_sync #(
    .STAGES (2)
  ) u_sync (
    .uclk       (uclk),
    .rst        (rst),
    .din        (bus.rxd),
    .dout       (rxd_s),
    .fall_pulse (fall_pulse)
  );

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      data_cnt_q <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      data_cnt_q <= data_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + 16'd1;
    data_cnt_d = data_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      StIdle: begin
        clk_cnt_d  = '0;
        data_cnt_d = '0;
        if (fall_pulse) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          // line back high at mid-start means a glitch: drop it silently
          state_d   = rxd_s ? StIdle : StData;
        end
      end

      StData: begin
        if (clk_cnt_q == BPS_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s, shift_q[DATA_W-1:1]};
          if (data_cnt_q == LAST_BIT) begin
            data_cnt_d = '0;
            state_d    = StStop;
          end else begin
            data_cnt_d = data_cnt_q + 4'd1;
          end
        end
      end

      StStop: begin
        if (clk_cnt_q == BPS_LAST) begin
          clk_cnt_d = '0;
          if (rxd_s) begin
            // load here so rx_data changes in the same cycle rx_valid is decoded from StDone
            rx_data_d = shift_q;
            state_d   = StDone;
          end else begin
            state_d = StErr;
          end
        end
      end

      StDone: begin
        clk_cnt_d = '0;
        state_d   = StIdle;
      end

      StErr: begin
        // clk_cnt == 0 marks the first ERR cycle; pinning it at 1 keeps rx_err single-shot
        clk_cnt_d = 16'd1;
        if (rxd_s) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d    = StIdle;
        clk_cnt_d  = '0;
        data_cnt_d = '0;
      end
    endcase
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = (state_q == StDone);
  assign bus.rx_err   = (state_q == StErr) && (clk_cnt_q == 16'd0);
  assign bus.rx_busy  = (state_q != StIdle);

  a_valid_pulse : assert property (@(posedge uclk) disable iff (rst)
    bus.rx_valid |=> !bus.rx_valid);

  a_err_pulse : assert property (@(posedge uclk) disable iff (rst)
    bus.rx_err |=> !bus.rx_err);

  a_exclusive : assert property (@(posedge uclk) disable iff (rst)
    !(bus.rx_valid && bus.rx_err));

  c_valid : cover property (@(posedge uclk) disable iff (rst) bus.rx_valid);
  c_err   : cover property (@(posedge uclk) disable iff (rst) bus.rx_err);
  c_both_seen : cover property (@(posedge uclk) disable iff (rst)
    bus.rx_err ##[1:$] bus.rx_valid);

endmodule
